// File: rtl/axi_noc_pkg.sv
// -----------------------------------------------------------------------------
// axi_noc_pkg
// Shared types and helpers for the axi_noc fabric arbiters.
//   arb_state_e : packet arbiter state (ST_IDLE / ST_BURST)
//   rr_pick_t   : result of a rotating-priority pick {found, idx}
//   rr_pick()   : first set bit of vec scanning ptr, ptr+1, ... modulo n
// -----------------------------------------------------------------------------
package axi_noc_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Widest requester vector any noc arbiter uses; narrower callers zero-pad.
    localparam int RR_MAX_N = 16;
    localparam int RR_IDX_W = 4;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // Rotating priority pick. n may be any value 1..RR_MAX_N; the wrap is an
    // explicit compare so non power-of-two requester counts work.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] vec,
                                         input logic [RR_IDX_W-1:0] ptr,
                                         input int                  n);
        rr_pick_t res;
        int       j;
        res = '0;
        for (int k = 0; k < RR_MAX_N; k++) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) begin
                    j = j - n;
                end
                if (!res.found && vec[j[RR_IDX_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = j[RR_IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick_nreq.sv
// -----------------------------------------------------------------------------
// rr_pick_nreq
// Combinational rotating priority encoder for N requesters.
//   vec_i   [N]  : request vector
//   ptr_i   [IW] : highest-priority index this cycle (must be < N)
//   idx_o   [IW] : first requesting index scanning ptr_i upward, modulo N
//   found_o      : any bit of vec_i set
// -----------------------------------------------------------------------------
module rr_pick_nreq
    import axi_noc_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    rr_pick_t res;

    always_comb begin
        res     = rr_pick(RR_MAX_N'(vec_i), RR_IDX_W'(ptr_i), N);
        idx_o   = IW'(res.idx);
        found_o = res.found;
    end

endmodule

// File: rtl/multififo_pkt_arb.sv
// -----------------------------------------------------------------------------
// multififo_pkt_arb
// Packet-atomic round-robin write arbiter in front of a single-write multififo.
// A granted requester keeps the fifo write port until its last beat is taken,
// so packets never interleave in the fifo.
//   clk, rst_n            : clock, asynchronous active-low reset
//   softreset             : synchronous clear of all arbiter state
//   req_valid/last [NREQ] : per-requester beat valid / last-beat flag
//   req_data [WIDTH*NREQ] : packed beats, requester i at [WIDTH*(i+1)-1:WIDTH*i]
//   req_ready [NREQ]      : beat accepted when valid & ready
//   fifo_writes, fifo_din : fifo write strobe and data
//   fifo_frees, fifo_taken: fifo free-slot count and write-taken flag
//   owner                 : current / last owner index
//   busy                  : a packet is in progress (BURST)
//   pkt_done              : pulses with the accepted last beat
//   err                   : sticky, a write was issued that the fifo did not take
// -----------------------------------------------------------------------------
module multififo_pkt_arb
    import axi_noc_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int NREQ    = 4,
    parameter  int MINFREE = 2,
    localparam int IDXW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  softreset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [WIDTH*NREQ-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  fifo_writes,
    output logic [WIDTH-1:0]      fifo_din,
    input  logic [15:0]           fifo_frees,
    input  logic                  fifo_taken,
    output logic [IDXW-1:0]       owner,
    output logic                  busy,
    output logic                  pkt_done,
    output logic                  err
);

    arb_state_e      state_q, state_d;
    logic [IDXW-1:0] owner_q, owner_d;
    logic [IDXW-1:0] ptr_q,   ptr_d;
    logic            err_q,   err_d;

    logic [IDXW-1:0] pick_idx;
    logic            pick_found;
    logic            headroom;

    assign headroom = (fifo_frees >= 16'(MINFREE));

    rr_pick_nreq #(.N(NREQ)) u_pick (
        .vec_i   (req_valid),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational processes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic. softreset overrides every other update.
    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        err_d   = err_q | (fifo_writes & ~fifo_taken);
        if (softreset) begin
            state_d = ST_IDLE;
            owner_d = '0;
            ptr_d   = '0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // Grant only; no beat moves in the arbitration cycle.
                    if (pick_found && headroom) begin
                        owner_d = pick_idx;
                        state_d = ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (pkt_done) begin
                        state_d = ST_IDLE;
                        ptr_d   = (owner_q == IDXW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs. Only the owner sees ready; a valid bubble from the owner simply
    // produces no write and keeps the lock.
    always_comb begin
        req_ready   = '0;
        fifo_writes = 1'b0;
        fifo_din    = '0;
        pkt_done    = 1'b0;
        if (!softreset && state_q == ST_BURST) begin
            req_ready[owner_q] = (fifo_frees != 16'd0);
            fifo_writes        = req_valid[owner_q] & req_ready[owner_q];
            pkt_done           = fifo_writes & req_last[owner_q];
            for (int i = 0; i < NREQ; i++) begin
                if (owner_q == IDXW'(i)) begin
                    fifo_din = req_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign owner = owner_q;
    assign busy  = (state_q == ST_BURST);
    assign err   = err_q;

endmodule

// File: tb/tb_multififo_pkt_arb.sv
// -----------------------------------------------------------------------------
// tb_multififo_pkt_arb
// Directed bench for multififo_pkt_arb (WIDTH=32, NREQ=4, MINFREE=2). Inputs
// change on the falling edge; outputs are sampled 1 ns later, so each step
// observes one full clock cycle of the arbiter.
// -----------------------------------------------------------------------------
module tb_multififo_pkt_arb;

    localparam int WIDTH   = 32;
    localparam int NREQ    = 4;
    localparam int MINFREE = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  softreset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_last;
    logic [WIDTH*NREQ-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_writes;
    logic [WIDTH-1:0]      fifo_din;
    logic [15:0]           fifo_frees;
    logic                  fifo_taken;
    logic [1:0]            owner;
    logic                  busy;
    logic                  pkt_done;
    logic                  err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multififo_pkt_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .MINFREE(MINFREE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .softreset   (softreset),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_writes (fifo_writes),
        .fifo_din    (fifo_din),
        .fifo_frees  (fifo_frees),
        .fifo_taken  (fifo_taken),
        .owner       (owner),
        .busy        (busy),
        .pkt_done    (pkt_done),
        .err         (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check one cycle's outputs, then advance to the next falling edge.
    task automatic cyc(input string tag, input logic e_busy, input logic [1:0] e_owner,
                       input logic [3:0] e_ready, input logic e_wr,
                       input logic [31:0] e_din, input logic e_done);
        #1;
        check({tag, ".busy"},     32'(busy),        32'(e_busy));
        check({tag, ".owner"},    32'(owner),       32'(e_owner));
        check({tag, ".ready"},    32'(req_ready),   32'(e_ready));
        check({tag, ".writes"},   32'(fifo_writes), 32'(e_wr));
        check({tag, ".din"},      fifo_din,         e_din);
        check({tag, ".pkt_done"}, 32'(pkt_done),    32'(e_done));
        @(negedge clk);
    endtask

    task automatic beat(input int r, input logic v, input logic l, input logic [31:0] d);
        req_valid[r]             = v;
        req_last[r]              = l;
        req_data[r*WIDTH +: WIDTH] = d;
    endtask

    initial begin
        rst_n      = 1'b0;
        softreset  = 1'b0;
        req_valid  = '0;
        req_last   = '0;
        req_data   = '0;
        fifo_frees = 16'd8;
        fifo_taken = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        cyc("rst", 0, 0, 4'b0000, 0, 32'h0, 0);
        check("rst.err", 32'(err), 32'h0);
        rst_n = 1'b1;
        cyc("rst_rel", 0, 0, 4'b0000, 0, 32'h0, 0);

        // Lone 3-beat packet from requester 2
        beat(2, 1, 0, 32'hA000_0000);
        cyc("t1_arb", 0, 0, 4'b0000, 0, 32'h0, 0);
        cyc("t1_b0", 1, 2, 4'b0100, 1, 32'hA000_0000, 0);
        beat(2, 1, 0, 32'hA000_0001);
        cyc("t1_b1", 1, 2, 4'b0100, 1, 32'hA000_0001, 0);
        beat(2, 1, 1, 32'hA000_0002);
        cyc("t1_b2", 1, 2, 4'b0100, 1, 32'hA000_0002, 1);
        // ptr is now 3: with 0 and 3 requesting, 3 wins, then ptr wraps to 0
        beat(2, 0, 0, 32'h0);
        beat(0, 1, 1, 32'hB000_0000);
        beat(3, 1, 1, 32'hB000_0003);
        cyc("t1_idle", 0, 2, 4'b0000, 0, 32'h0, 0);
        cyc("ptr3", 1, 3, 4'b1000, 1, 32'hB000_0003, 1);
        beat(3, 0, 0, 32'h0);
        cyc("wrap_idle", 0, 3, 4'b0000, 0, 32'h0, 0);
        cyc("wrap0", 1, 0, 4'b0001, 1, 32'hB000_0000, 1);
        beat(0, 0, 0, 32'h0);
        cyc("t1_end", 0, 0, 4'b0000, 0, 32'h0, 0);

        // softreset in IDLE returns ptr to 0
        softreset = 1'b1;
        cyc("srst_idle", 0, 0, 4'b0000, 0, 32'h0, 0);
        softreset = 1'b0;

        // Two contending 2-beat packets: 0 completes before 1 starts
        beat(0, 1, 0, 32'hC000_0000);
        beat(1, 1, 0, 32'hD000_0000);
        cyc("t2_arb", 0, 0, 4'b0000, 0, 32'h0, 0);
        cyc("t2_c0", 1, 0, 4'b0001, 1, 32'hC000_0000, 0);
        beat(0, 1, 1, 32'hC000_0001);
        cyc("t2_c1", 1, 0, 4'b0001, 1, 32'hC000_0001, 1);
        beat(0, 0, 0, 32'h0);
        cyc("t2_gap", 0, 0, 4'b0000, 0, 32'h0, 0);
        cyc("t2_d0", 1, 1, 4'b0010, 1, 32'hD000_0000, 0);
        beat(1, 1, 1, 32'hD000_0001);
        cyc("t2_d1", 1, 1, 4'b0010, 1, 32'hD000_0001, 1);
        beat(1, 0, 0, 32'h0);
        cyc("t2_end", 0, 1, 4'b0000, 0, 32'h0, 0);

        // Fifo full for 3 cycles mid-packet
        beat(2, 1, 0, 32'hE000_0000);
        cyc("t3_arb", 0, 1, 4'b0000, 0, 32'h0, 0);
        cyc("t3_e0", 1, 2, 4'b0100, 1, 32'hE000_0000, 0);
        beat(2, 1, 0, 32'hE000_0001);
        fifo_frees = 16'd0;
        cyc("t3_full0", 1, 2, 4'b0000, 0, 32'hE000_0001, 0);
        cyc("t3_full1", 1, 2, 4'b0000, 0, 32'hE000_0001, 0);
        cyc("t3_full2", 1, 2, 4'b0000, 0, 32'hE000_0001, 0);
        fifo_frees = 16'd1;
        cyc("t3_e1", 1, 2, 4'b0100, 1, 32'hE000_0001, 0);
        fifo_frees = 16'd8;
        beat(2, 1, 1, 32'hE000_0002);
        cyc("t3_e2", 1, 2, 4'b0100, 1, 32'hE000_0002, 1);
        beat(2, 0, 0, 32'h0);
        cyc("t3_end", 0, 2, 4'b0000, 0, 32'h0, 0);

        // Headroom below MINFREE holds off the grant
        fifo_frees = 16'd1;
        beat(0, 1, 1, 32'hF000_0000);
        cyc("t4_wait0", 0, 2, 4'b0000, 0, 32'h0, 0);
        cyc("t4_wait1", 0, 2, 4'b0000, 0, 32'h0, 0);
        cyc("t4_wait2", 0, 2, 4'b0000, 0, 32'h0, 0);
        fifo_frees = 16'd2;
        cyc("t4_arb", 0, 2, 4'b0000, 0, 32'h0, 0);
        fifo_frees = 16'd8;
        cyc("t4_f0", 1, 0, 4'b0001, 1, 32'hF000_0000, 1);
        beat(0, 0, 0, 32'h0);
        cyc("t4_end", 0, 0, 4'b0000, 0, 32'h0, 0);

        // softreset mid-burst; rearbitration restarts from index 0
        beat(3, 1, 0, 32'h6000_0000);
        cyc("t5_arb", 0, 0, 4'b0000, 0, 32'h0, 0);
        cyc("t5_g0", 1, 3, 4'b1000, 1, 32'h6000_0000, 0);
        beat(3, 1, 0, 32'h6000_0001);
        softreset = 1'b1;
        cyc("t5_srst", 1, 3, 4'b0000, 0, 32'h0, 0);
        softreset = 1'b0;
        beat(0, 1, 1, 32'h7000_0000);
        #1 check("t5.err", 32'(err), 32'h0);
        cyc("t5_after", 0, 0, 4'b0000, 0, 32'h0, 0);
        cyc("t5_rearb", 1, 0, 4'b0001, 1, 32'h7000_0000, 1);
        beat(0, 0, 0, 32'h0);
        beat(3, 0, 0, 32'h0);
        cyc("t5_end", 0, 0, 4'b0000, 0, 32'h0, 0);

        // Write not taken by the fifo sets sticky err
        beat(1, 1, 1, 32'h8000_0001);
        cyc("t6_arb", 0, 0, 4'b0000, 0, 32'h0, 0);
        check("t6.err_pre", 32'(err), 32'h0);
        fifo_taken = 1'b0;
        cyc("t6_w", 1, 1, 4'b0010, 1, 32'h8000_0001, 1);
        fifo_taken = 1'b1;
        beat(1, 0, 0, 32'h0);
        #1 check("t6.err_set", 32'(err), 32'h1);
        cyc("t6_idle", 0, 1, 4'b0000, 0, 32'h0, 0);
        check("t6.err_hold", 32'(err), 32'h1);
        softreset = 1'b1;
        cyc("t6_srst", 0, 1, 4'b0000, 0, 32'h0, 0);
        softreset = 1'b0;
        #1 check("t6.err_clr", 32'(err), 32'h0);
        check("t6.owner_clr", 32'(owner), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multififo_pkt_arb.md
Name: multififo_pkt_arb

Overview:
- Packet-atomic round-robin write arbiter that shares one single-write multififo (w1_rN family) between NREQ requesters in the axi_noc fabric.
- Each requester presents one beat per cycle with a last flag.
- Once granted, a requester owns the fifo write port until its last beat is accepted, so packets never interleave in the fifo.
- Fifo space is checked via the fifo frees/taken outputs; a new packet may start only when a minimum headroom is free.

Parameters:
- WIDTH, 32, beat width in bits; must equal the fifo WIDTH.
- NREQ, 4, number of requesters, 2..16.
- MINFREE, 2, frees required to start a new packet, 1..DEPTH.
- IDXW, $clog2(NREQ), owner index width (localparam).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- softreset  input  1  synchronous clear of arbiter state; also routed to the fifo by the parent.
- req_valid  input  NREQ  beat valid per requester.
- req_last  input  NREQ  last beat of packet per requester.
- req_data  input  WIDTH*NREQ  packed beats; requester i occupies [WIDTH*(i+1)-1:WIDTH*i].
- req_ready  output  NREQ  beat accepted this cycle when valid&ready.
- fifo_writes  output  1  to fifo writes.
- fifo_din  output  WIDTH  to fifo din.
- fifo_frees  input  16  from fifo frees.
- fifo_taken  input  1  from fifo taken.
- owner  output  IDXW  current/last owner index.
- busy  output  1  high in BURST state.
- pkt_done  output  1  one-cycle pulse when a last beat is accepted.
- err  output  1  sticky protocol error.

Behaviour:
- Reset (rst_n low or softreset high): state=IDLE, owner=0, rr pointer ptr=0, err=0. Combinationally, req_ready=0, fifo_writes=0, pkt_done=0, fifo_din=0. softreset takes priority over all other updates.
- States: IDLE and BURST.
- IDLE: when any req_valid is set and fifo_frees>=MINFREE, pick the first valid index scanning ptr, ptr+1, ... modulo NREQ.
  - Register it into owner; state<=BURST.
  - No beat transfers in IDLE, so arbitration costs exactly 1 cycle.
  - Winner's first beat is accepted no earlier than the next cycle.
- BURST:
  - req_ready[owner] = (fifo_frees>=1); all other req_ready bits = 0.
  - fifo_writes = req_valid[owner] & req_ready[owner]; fifo_din = owner slice of req_data, else 0.
  - Transfer with req_last[owner]=1: state<=IDLE, ptr<=(owner+1) mod NREQ, pkt_done pulses in the same cycle as the transfer.
  - Owner deasserting valid mid-packet holds the lock indefinitely; the bubble is legal and does not change the grant.
- Back-to-back: after a last beat the next packet's first beat occurs 2 cycles later at earliest (IDLE cycle, then BURST).
- Full: at fifo_frees==0 in BURST, ready drops and no write is issued. The fifo's registered count update makes frees valid the same cycle, so writes resume the cycle after a read frees space.
- Single-beat packet (valid&last on the first BURST cycle): 1 beat, then IDLE.
- MINFREE > frees in IDLE: wait in IDLE, no grant; ptr is unchanged.
- err set when fifo_writes=1 and fifo_taken=0; cleared only by reset/softreset.
- Other requesters' valid/last are ignored while not owner. They must hold data stable until ready (AXI rule); the arbiter does not check this.
- ptr arithmetic: wrap with an explicit compare; NREQ need not be a power of 2.

Decomposition:
- Shared package axi_noc_pkg: arbiter state enum (IDLE, BURST) and a rotate-priority-pick function (vector, ptr -> index, found).
- One natural sub-module, rr_pick_nreq: a combinational rotating priority encoder, reused by other noc arbiters.
- Fifo instantiation stays in the parent.

Test Plan:
- NREQ=4, only req 2 sends a 3-beat packet, frees=8 -> owner=2 registered at cycle 1; writes at cycles 2,3,4; pkt_done at cycle 4; ptr=3; busy low at cycle 5.
- Reqs 0 and 1 both valid with 2-beat packets, ptr=0 -> req 0's packet fully written first, then req 1's packet after 1 IDLE cycle. No interleaving in fifo contents.
- Owner mid-packet with frees forced to 0 for 3 cycles -> req_ready and fifo_writes held 0 for those 3 cycles, beat accepted on the first cycle frees=1, beat order preserved.
- MINFREE=2, frees=1, req 0 valid -> stays IDLE with no grant until frees>=2, then grants req 0.
- softreset asserted during BURST after 1 of 3 beats -> next cycle state=IDLE, ptr=0, err=0, no fifo_writes. Rearbitration then starts from index 0.
- Force fifo_taken=0 during a write -> err=1 next cycle and remains 1 until softreset.
